// File: rtl/bus_pair_fifo.sv
// bus_pair_fifo: two-channel paired FIFO with valid/ready on both sides.
//   Channel 0 is a descending bus [HI:LO]; channel 1 is an ascending bus [LO:HI].
//   Both are stored together as one entry in a DEPTH-deep circular buffer.
//   Every bit is mapped by its index k in LO..HI, never by its position in the vector.
//   SWAP="TRUE" exchanges the channels on the output side, again by index.
// Optional build macro: BUS_PAIR_FIFO_ERR_EN adds a sticky 'err' output that
//   flags overflow and underflow attempts.
module bus_pair_fifo #(
    parameter int    HI    = 2,
    parameter int    LO    = -2,
    parameter int    DEPTH = 4,
    parameter string SWAP  = "FALSE"
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [HI:LO]                 i0,
    input  logic [LO:HI]                 i1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [HI:LO]                 o0,
    output logic [LO:HI]                 o1,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef BUS_PAIR_FIFO_ERR_EN
    ,
    output logic                         err
`endif
);

    localparam int W  = HI - LO + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Any SWAP string other than "TRUE" leaves the channels in place.
    localparam bit SWAP_EN = (SWAP == "TRUE");

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
    localparam logic [PW-1:0] ONE_PTR    = PW'(1);

    // Storage is index-normalised: bit gi of an entry holds bus index LO+gi,
    // so the descending and ascending buses share one layout.
    logic [W-1:0]  mem0 [DEPTH];
    logic [W-1:0]  mem1 [DEPTH];

    logic [W-1:0]  wdata0;
    logic [W-1:0]  wdata1;
    logic [W-1:0]  head0;
    logic [W-1:0]  head1;

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    logic          push;
    logic          pop;

    // Handshake flags come only from registered occupancy, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);
    assign count     = count_reg;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Occupancy bookkeeping: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + ONE_COUNT;
            2'b01:   count_next = count_reg - ONE_COUNT;
            default: count_next = count_reg;
        endcase
    end

    // Pointers and occupancy; reset discards all entries immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                // DEPTH is a power of two, so the natural wrap of the
                // pointer takes it from DEPTH-1 to 0 with no gap.
                wr_ptr_reg <= wr_ptr_reg + ONE_PTR;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ONE_PTR;
            end
            count_reg <= count_next;
        end
    end

    // Entry storage; contents survive reset because the empty flag masks them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem0[wr_ptr_reg] <= wdata0;
            mem1[wr_ptr_reg] <= wdata1;
        end
    end

    // The head entry is read straight from storage so a push at edge n is
    // visible right after edge n.
    assign head0 = mem0[rd_ptr_reg];
    assign head1 = mem1[rd_ptr_reg];

    // Per-index mapping between the external buses and the storage layout.
    // Outputs are forced to zero while empty so stale entries never leak.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        localparam int K = LO + gi;

        assign wdata0[gi] = i0[K];
        assign wdata1[gi] = i1[K];

        if (SWAP_EN) begin : g_swap
            assign o0[K] = out_valid & head1[gi];
            assign o1[K] = out_valid & head0[gi];
        end else begin : g_straight
            assign o0[K] = out_valid & head0[gi];
            assign o1[K] = out_valid & head1[gi];
        end
    end

`ifdef BUS_PAIR_FIFO_ERR_EN
    logic err_reg;

    // Sticky flag for refused transfers; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if ((in_valid && !in_ready) || (out_ready && !out_valid)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_bus_pair_fifo.sv
// Testbench for bus_pair_fifo (HI=2, LO=-2, DEPTH=4): a straight instance and a
// SWAP="TRUE" instance driven by the same stimulus, checked against a queue model.
module tb_bus_pair_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:-2] i0 = '0;
    logic [-2:2] i1 = '0;

    logic        in_ready, out_valid;
    logic [2:-2] o0;
    logic [-2:2] o1;
    logic [2:0]  count;

    logic        s_in_ready, s_out_valid;
    logic [2:-2] s_o0;
    logic [-2:2] s_o1;
    logic [2:0]  s_count;

`ifdef BUS_PAIR_FIFO_ERR_EN
    logic err, s_err;
`endif

    bus_pair_fifo #(.HI(2), .LO(-2), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .i0(i0), .i1(i1),
        .out_valid(out_valid), .out_ready(out_ready), .o0(o0), .o1(o1),
        .count(count)
`ifdef BUS_PAIR_FIFO_ERR_EN
        , .err(err)
`endif
    );

    bus_pair_fifo #(.HI(2), .LO(-2), .DEPTH(4), .SWAP("TRUE")) dut_swap (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready), .i0(i0), .i1(i1),
        .out_valid(s_out_valid), .out_ready(out_ready), .o0(s_o0), .o1(s_o1),
        .count(s_count)
`ifdef BUS_PAIR_FIFO_ERR_EN
        , .err(s_err)
`endif
    );

    always #5 clk = ~clk;

    // Model entry: raw packed values of i0 ([2:-2]) and i1 ([-2:2]) as pushed.
    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
    } entry_t;

    entry_t q[$];
    bit     err_m = 1'b0;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Index-wise exchange between a [2:-2] and a [-2:2] vector: index k sits
    // at packed position k+2 in one and 2-k in the other, so the bits reverse.
    function automatic logic [4:0] rev5(input logic [4:0] v);
        logic [4:0] r;
        for (int j = 0; j < 5; j++) r[j] = v[4-j];
        return r;
    endfunction

    task automatic check_state();
        int n;
        n = q.size();
        check("count", 32'(count), 32'(n));
        check("out_valid", 32'(out_valid), 32'(n != 0));
        check("in_ready", 32'(in_ready), 32'(n != 4));
        check("o0", 32'(o0), (n != 0) ? 32'(q[0].a) : 32'd0);
        check("o1", 32'(o1), (n != 0) ? 32'(q[0].b) : 32'd0);
        check("s_count", 32'(s_count), 32'(n));
        check("s_o0", 32'(s_o0), (n != 0) ? 32'(rev5(q[0].b)) : 32'd0);
        check("s_o1", 32'(s_o1), (n != 0) ? 32'(rev5(q[0].a)) : 32'd0);
`ifdef BUS_PAIR_FIFO_ERR_EN
        check("err", 32'(err), 32'(err_m));
        check("s_err", 32'(s_err), 32'(err_m));
`endif
    endtask

    // One clock with the currently driven inputs; model updated, then checked.
    task automatic cycle();
        bit     push_ok, pop_ok;
        entry_t e;
        push_ok = in_valid && (q.size() < 4);
        pop_ok  = out_ready && (q.size() > 0);
        if ((in_valid && q.size() == 4) || (out_ready && q.size() == 0)) err_m = 1'b1;
        e.a = i0;
        e.b = i1;
        @(posedge clk);
        #1;
        if (pop_ok) begin
            $display("pop  a=%02h b=%02h", q[0].a, q[0].b);
            void'(q.pop_front());
        end
        if (push_ok) begin
            q.push_back(e);
            $display("push a=%02h b=%02h", e.a, e.b);
        end
        check_state();
    endtask

    task automatic drive(input bit v, input bit r, input logic [4:0] a, input logic [4:0] b);
        in_valid  = v;
        out_ready = r;
        i0 = a;
        i1 = b;
    endtask

    initial begin
        // Reset then idle.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();
        drive(0, 0, 5'h00, 5'h00);
        cycle();

        // Index-positional single push.
        drive(1, 0, 5'b10110, 5'b01001);
        cycle();
        drive(0, 0, 5'h00, 5'h00);
        check("o0[2]", 32'(o0[2]), 32'd1);
        check("o0[-2]", 32'(o0[-2]), 32'd0);
        check("o1[-2]", 32'(o1[-2]), 32'd0);
        check("o1[2]", 32'(o1[2]), 32'd1);
        drive(0, 1, 5'h00, 5'h00);
        cycle();

        // Fill to full, refused 5th push, drain in order.
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 5'(k), 5'(k));
            cycle();
        end
        drive(1, 0, 5'h1E, 5'h1E);
        cycle();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 5'h00, 5'h00);
            cycle();
        end

        // Three held entries, then steady push+pop across pointer wrap.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 5'(k + 8), 5'(k + 16));
            cycle();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1, 1, 5'(k + 11), 5'(k + 3));
            cycle();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 5'h00, 5'h00);
            cycle();
        end

        // Swap instance with all-ones / all-zeros, then drain.
        drive(1, 0, 5'h1F, 5'h00);
        cycle();
        check("swap_o0", 32'(s_o0), 32'd0);
        check("swap_o1", 32'(s_o1), 32'h1F);
        drive(0, 1, 5'h00, 5'h00);
        cycle();

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom), 5'($urandom));
            cycle();
        end

        // Asynchronous reset with entries held.
        drive(0, 1, 5'h00, 5'h00);
        repeat (4) cycle();
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 5'(k + 5), 5'(k + 9));
            cycle();
        end
        drive(0, 0, 5'h00, 5'h00);
        check("pre_rst_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_o0", 32'(o0), 32'd0);
        check("async_s_count", 32'(s_count), 32'd0);
        q.delete();
        err_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();

        // Traffic after reset release.
        drive(1, 0, 5'h15, 5'h0A);
        cycle();
        drive(1, 1, 5'h0C, 5'h13);
        cycle();
        drive(0, 1, 5'h00, 5'h00);
        repeat (2) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_pair_fifo.md
# bus_pair_fifo

Parametrised two-channel buffer that carries a descending-range bus (`[HI:LO]`) and an ascending-range bus (`[LO:HI]`) as one paired entry through a DEPTH-deep FIFO with valid/ready handshakes on both sides. It is the sequential successor of the plain two-bus model cell: it allows signed, non-zero-based index ranges, a configurable depth and an optional channel swap. It sits between a producer and a consumer instance on the paired `bus0`/`bus1` nets of a netlist top level, and is exercised through the Verilog backend.

## Interface
- `HI`, default 2: upper index of both buses; may be negative.
- `LO`, default -2: lower index of both buses; `LO <= HI` required; W = HI-LO+1.
- `DEPTH`, default 4: number of entries; power of two, >= 2.
- `SWAP`, default "FALSE": string; "TRUE" exchanges the channels on the output side.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: producer offers an entry.
- `in_ready` out 1: FIFO accepts an entry.
- `i0` in `[HI:LO]`: channel 0 data, descending range.
- `i1` in `[LO:HI]`: channel 1 data, ascending range.
- `out_valid` out 1: head entry presented.
- `out_ready` in 1: consumer takes the head entry.
- `o0` out `[HI:LO]`: channel 0 head data.
- `o1` out `[LO:HI]`: channel 1 head data.
- `count` out `$clog2(DEPTH+1)`: current occupancy, 0..DEPTH.

## Operation
- Push: `in_valid && in_ready` at a rising edge stores {i0, i1} at the write pointer.
- Pop: `out_valid && out_ready` at a rising edge advances the read pointer.
- `in_ready = (count != DEPTH)`. This depends only on registered state; there is no combinational path from `out_ready`.
- `out_valid = (count != 0)`.
- Pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no gap.
- Simultaneous push and pop: both take effect and `count` is unchanged. When full, push is refused even if a pop occurs in the same cycle.
- Empty state: `o0` and `o1` are driven to all-zero, never to stale entries.
- Bit mapping is positional by index, never by left-to-right position: `o0[k]` = stored `i0[k]` and `o1[k]` = stored `i1[k]` for every k in LO..HI.
- SWAP="TRUE": `o0[k]` = stored `i1[k]` and `o1[k]` = stored `i0[k]`; the swap is by index. Any other SWAP string behaves as "FALSE".
- Reset: `count`=0, pointers=0, `out_valid`=0, `in_ready`=1, `o0`=`o1`=0. Storage contents need not be cleared.
- Reset asserted mid-operation discards all entries immediately. The first push after deassertion lands in slot 0.

## Timing
- Latency: an entry pushed at edge n is visible on `o0`/`o1` with `out_valid`=1 after edge n; there is no same-cycle bypass.
- A push into an empty FIFO with `out_ready` already high pops at edge n+1.
- Throughput: one entry per cycle in steady state when neither full nor empty.
- `count` updates at the same edge as the push or pop.
- `rst` takes effect asynchronously. Release is synchronous to `clk` by the surrounding system.

## Configuration
- `BUS_PAIR_FIFO_ERR_EN` defined adds output `err` (1 bit, reset 0).
  - `err` is sticky and is set at the edge where `in_valid && !in_ready` (overflow attempt) or `out_ready && !out_valid` (underflow attempt).
  - It is cleared only by `rst`.
  - Attempted transfers are still ignored; the data path is unaffected.
- Macro undefined: no `err` port exists, and refused transfers are silently ignored.

## Test plan
- Reset then idle, HI=2, LO=-2, DEPTH=4: `count`=0, `out_valid`=0, `in_ready`=1, `o0`=`o1`=5'b00000.
- Push i0=5'b10110 (`i0[2]`=1, `i0[-2]`=0) and i1=5'b01001 (`i1[-2]`=0, `i1[2]`=1), `out_ready`=0: the next cycle shows `out_valid`=1, `o0[2]`=1, `o0[-2]`=0, `o1[-2]`=0, `o1[2]`=1, `count`=1.
- Push 0x01..0x04 with `out_ready`=0: `count`=4 and `in_ready`=0. A 5th push is refused. Draining yields 0x01, 0x02, 0x03, 0x04 in order, then `out_valid`=0 and outputs are 0.
- Fill with 3 entries, then hold `in_valid`=`out_ready`=1 for 10 cycles with incrementing data: `count` stays 3 and the output order is strictly FIFO across pointer wrap.
- SWAP="TRUE", push i0=5'h1F and i1=5'h00: `o0`=0 and `o1`=5'h1F. Assert `rst` mid-stream with 2 entries held: `count` is 0 and `out_valid` is 0 immediately, without waiting for a clock edge.
- With `BUS_PAIR_FIFO_ERR_EN` defined: push while full sets `err`=1 and it holds through subsequent valid traffic until `rst`. Built without the macro, the same stimulus compiles without an `err` port.
